// File: rtl/rcpu_mem_arbiter.sv
// Arbitrates one downstream memory port between the RCPU bus and an auxiliary master.
// CPU writes are posted through a small FIFO; CPU reads and aux requests stall until done.
module rcpu_mem_arbiter #(
  parameter int unsigned N          = 32,
  parameter int unsigned M          = 16,
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] cpu_addr,
  input  logic [M-1:0] cpu_wdata,
  input  logic         cpu_re,
  input  logic         cpu_we,
  output logic         cpu_ready,
  output logic [M-1:0] cpu_rdata,
  input  logic         aux_req,
  input  logic         aux_we,
  input  logic [N-1:0] aux_addr,
  input  logic [M-1:0] aux_wdata,
  output logic         aux_ack,
  output logic [M-1:0] aux_rdata,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [M-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [M-1:0] mem_rdata,
  output logic         wbuf_overflow
);

  localparam int unsigned PtrW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StCpuWr,
    StCpuRd,
    StAux,
    StResp
  } state_e;

  state_e state_q, state_d;
  logic   last_aux_q, last_aux_d;

  logic [N-1:0]    wb_addr_q [WBUF_DEPTH];
  logic [N-1:0]    wb_addr_d [WBUF_DEPTH];
  logic [M-1:0]    wb_data_q [WBUF_DEPTH];
  logic [M-1:0]    wb_data_d [WBUF_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic         mem_req_q, mem_req_d;
  logic         mem_we_q, mem_we_d;
  logic [N-1:0] mem_addr_q, mem_addr_d;
  logic [M-1:0] mem_wdata_q, mem_wdata_d;
  logic         cpu_ready_q, cpu_ready_d;
  logic [M-1:0] cpu_rdata_q, cpu_rdata_d;
  logic         aux_ack_q, aux_ack_d;
  logic [M-1:0] aux_rdata_q, aux_rdata_d;
  logic         overflow_q, overflow_d;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic cpu_rd_ok;
  logic cpu_pending;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(WBUF_DEPTH));
  assign pop        = (state_q == StCpuWr) && mem_ack;
  assign push       = cpu_we && (!fifo_full || pop);
  // A read presented together with a write must queue behind that write.
  assign cpu_rd_ok   = cpu_re && !cpu_we && fifo_empty;
  assign cpu_pending = !fifo_empty || cpu_rd_ok;

  always_comb begin
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      wb_addr_d[wr_ptr_q] = cpu_addr;
      wb_data_d[wr_ptr_q] = cpu_wdata;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    if (cpu_we && !push) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_aux_d  = last_aux_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    aux_ack_d   = 1'b0;
    aux_rdata_d = aux_rdata_q;
    unique case (state_q)
      StIdle: begin
        // On a tie the master that did not win last time is served.
        if (cpu_pending && (!aux_req || last_aux_q)) begin
          last_aux_d = 1'b0;
          mem_req_d  = 1'b1;
          if (!fifo_empty) begin
            state_d     = StCpuWr;
            mem_we_d    = 1'b1;
            mem_addr_d  = wb_addr_q[rd_ptr_q];
            mem_wdata_d = wb_data_q[rd_ptr_q];
          end else begin
            state_d    = StCpuRd;
            mem_we_d   = 1'b0;
            mem_addr_d = cpu_addr;
          end
        end else if (aux_req) begin
          last_aux_d  = 1'b1;
          state_d     = StAux;
          mem_req_d   = 1'b1;
          mem_we_d    = aux_we;
          mem_addr_d  = aux_addr;
          mem_wdata_d = aux_wdata;
        end
      end
      StCpuWr: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StIdle;
        end
      end
      StCpuRd: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          cpu_rdata_d = mem_rdata;
          cpu_ready_d = 1'b1;
          state_d     = StResp;
        end
      end
      StAux: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) begin
            aux_rdata_d = mem_rdata;
          end
          aux_ack_d = 1'b1;
          state_d   = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      last_aux_q  <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      aux_ack_q   <= 1'b0;
      aux_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_aux_q  <= last_aux_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      aux_ack_q   <= aux_ack_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end

  // Buffer storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    wb_addr_q <= wb_addr_d;
    wb_data_q <= wb_data_d;
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign cpu_ready     = cpu_ready_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign aux_ack       = aux_ack_q;
  assign aux_rdata     = aux_rdata_q;
  assign wbuf_overflow = overflow_q;

endmodule

// File: tb/tb_rcpu_mem_arbiter.sv
// Scoreboard bench for rcpu_mem_arbiter: the bench plays both masters and the memory,
// predicts read data from program-order memory contents and checks ordering and arbitration.
module tb_rcpu_mem_arbiter;

  localparam logic [23:0] AuxPage = 24'h4AA000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, aux_addr, mem_addr;
  logic [15:0] cpu_wdata, aux_wdata, mem_wdata, cpu_rdata, aux_rdata, mem_rdata;
  logic        cpu_re, cpu_we, cpu_ready, aux_req, aux_we, aux_ack;
  logic        mem_req, mem_we, mem_ack, wbuf_overflow;

  rcpu_mem_arbiter #(.N(32), .M(16), .WBUF_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack), .aux_rdata(aux_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wbuf_overflow(wbuf_overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [15:0] data; } wr_t;
  typedef struct { logic [31:0] addr; logic [15:0] data; } rd_t;
  typedef struct { logic we; logic [31:0] addr; logic [15:0] wdata; logic [15:0] rdata; } ax_t;

  wr_t         exp_wr_q[$];
  rd_t         exp_rd_q[$];
  ax_t         exp_aux_q[$];
  logic        grant_log[$];
  logic [32:0] txn_log[$];
  logic [15:0] ref_mem [logic [31:0]];
  logic [15:0] resp_mem [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int lat_fixed = 0;
  bit manual = 1'b0;
  bit manual_ack = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  function automatic logic [15:0] dflt(input logic [31:0] a);
    return {a[7:0] ^ 8'hA5, a[15:8]};
  endfunction

  function automatic logic [15:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic is_aux(input logic [31:0] a);
    return a[31:8] == AuxPage;
  endfunction

  // Downstream memory: returns stored data, acks after a chosen number of wait cycles.
  initial begin
    int  wcnt;
    bit  busy;
    busy = 1'b0;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (manual) begin
        mem_ack = manual_ack;
        busy = 1'b0;
      end else if (!mem_req) begin
        mem_ack = 1'b0;
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          wcnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
        end
        if (wcnt == 0) begin
          mem_ack = 1'b1;
          mem_rdata = resp_mem.exists(mem_addr) ? resp_mem[mem_addr] : dflt(mem_addr);
        end else begin
          wcnt--;
          mem_ack = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transaction or a response.
  initial begin
    logic req_prev;
    wr_t  w;
    rd_t  r;
    ax_t  e;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && !req_prev) grant_log.push_back(is_aux(mem_addr));
      req_prev = (mem_req === 1'b1);
      if (mem_req === 1'b1 && mem_ack) begin
        txn_log.push_back({mem_we, mem_addr});
        if (is_aux(mem_addr)) begin
          if (exp_aux_q.size() == 0) fail_evt("aux_txn_unexpected");
          else begin
            chk("aux_txn_we", mem_we, exp_aux_q[0].we);
            if (mem_we) chk("aux_txn_wdata", mem_wdata, exp_aux_q[0].wdata);
          end
        end else if (mem_we) begin
          if (exp_wr_q.size() == 0) fail_evt("cpu_write_unexpected");
          else begin
            w = exp_wr_q.pop_front();
            chk("cpu_write_addr", mem_addr, w.addr);
            chk("cpu_write_data", mem_wdata, w.data);
          end
        end else begin
          chk("read_after_writes", exp_wr_q.size(), 0);
          if (exp_rd_q.size() == 0) fail_evt("cpu_read_txn_unexpected");
          else chk("cpu_read_addr", mem_addr, exp_rd_q[0].addr);
        end
        if (mem_we) resp_mem[mem_addr] = mem_wdata;
      end
      if (cpu_ready === 1'b1) begin
        if (exp_rd_q.size() == 0) fail_evt("cpu_ready_unexpected");
        else begin
          r = exp_rd_q.pop_front();
          chk("cpu_rdata", cpu_rdata, r.data);
        end
      end
      if (aux_ack === 1'b1) begin
        if (exp_aux_q.size() == 0) fail_evt("aux_ack_unexpected");
        else begin
          e = exp_aux_q.pop_front();
          if (!e.we) chk("aux_rdata", aux_rdata, e.rdata);
        end
      end
    end
  end

  task automatic cpu_nop();
    @(posedge clk);
    #1;
    cpu_we = 1'b0;
    cpu_re = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [15:0] d, input bit acc);
    wr_t w;
    @(posedge clk);
    #1;
    cpu_we = 1'b1;
    cpu_re = 1'b0;
    cpu_addr = a;
    cpu_wdata = d;
    if (acc) begin
      w.addr = a;
      w.data = d;
      exp_wr_q.push_back(w);
      ref_mem[a] = d;
    end
  endtask

  // lat counts cycles from the one where cpu_re is first presented to the cpu_ready cycle.
  task automatic cpu_read(input logic [31:0] a, output int lat);
    rd_t r;
    @(posedge clk);
    #1;
    cpu_we = 1'b0;
    cpu_re = 1'b1;
    cpu_addr = a;
    r.addr = a;
    r.data = ref_rd(a);
    exp_rd_q.push_back(r);
    lat = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (cpu_ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) fail_evt("cpu_read_timeout");
    @(posedge clk);
    #1;
    cpu_re = 1'b0;
  endtask

  task automatic aux_xact(input logic we, input logic [31:0] a, input logic [15:0] d);
    ax_t e;
    bit  seen;
    @(posedge clk);
    #1;
    aux_req = 1'b1;
    aux_we = we;
    aux_addr = a;
    aux_wdata = d;
    e.we = we;
    e.addr = a;
    e.wdata = d;
    e.rdata = we ? 16'h0 : ref_rd(a);
    if (we) ref_mem[a] = d;
    exp_aux_q.push_back(e);
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (aux_ack === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_evt("aux_ack_timeout");
    @(posedge clk);
    #1;
    aux_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_we = 1'b0;
    cpu_re = 1'b0;
    aux_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_wr_q.delete();
    exp_rd_q.delete();
    exp_aux_q.delete();
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (exp_wr_q.size() == 0 && exp_rd_q.size() == 0 && exp_aux_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_evt(name);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2;
    rst = 1'b0;
    cpu_re = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 32'h0000_0104;
    cpu_wdata = '0;
    aux_req = 1'b1;
    aux_we = 1'b0;
    aux_addr = {AuxPage, 8'h01};
    aux_wdata = '0;
    lat_fixed = 1;

    // Reset with both masters requesting: everything must sit at zero.
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_ctrl", {mem_req, mem_we, cpu_ready, aux_ack, wbuf_overflow}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_data", {mem_wdata, cpu_rdata, aux_rdata}, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_re = 1'b0;
    aux_req = 1'b0;
    grant_log.delete();
    fork
      cpu_read(32'h0000_0104, lat);
      aux_xact(1'b0, {AuxPage, 8'h01}, 16'h0);
    join
    if (grant_log.size() == 0) fail_evt("first_grant_missing");
    else chk("first_grant_cpu", grant_log[0], 1'b0);

    // Zero-wait read latency.
    lat_fixed = 0;
    resp_mem[32'h0000_1234] = 16'hBEEF;
    ref_mem[32'h0000_1234] = 16'hBEEF;
    cpu_read(32'h0000_1234, lat);
    chk("read_latency", lat, 2);
    @(negedge clk);
    chk("cpu_ready_single", cpu_ready, 1'b0);

    // Posted writes drain before a following read of the same location.
    lat_fixed = -1;
    txn_log.delete();
    cpu_write(32'hD000_FFFF, 16'h0102, 1'b1);
    cpu_write(32'hD000_FFFE, 16'h0304, 1'b1);
    cpu_read(32'hD000_FFFE, lat);
    chk("wwr_count", txn_log.size(), 3);
    if (txn_log.size() >= 3) begin
      chk("wwr_0", txn_log[0], {1'b1, 32'hD000_FFFF});
      chk("wwr_1", txn_log[1], {1'b1, 32'hD000_FFFE});
      chk("wwr_2", txn_log[2], {1'b0, 32'hD000_FFFE});
    end

    // Contention with slow memory: grants must alternate.
    lat_fixed = 3;
    grant_log.delete();
    fork
      for (int i = 0; i < 4; i++) cpu_read(32'h0000_0100 + 32'(i), lat);
      for (int i = 0; i < 4; i++) aux_xact(i[0], {AuxPage, 8'h10} + 32'(i), 16'h1000 + 16'(i));
    join
    chk("alt_grant_count", grant_log.size(), 8);
    for (int i = 1; i < 8; i++) begin
      if (i < grant_log.size()) chk("alt_grant", grant_log[i], !grant_log[i-1]);
    end

    // Overflow: four writes fill the buffer, the fifth is dropped.
    do_reset();
    manual = 1'b1;
    manual_ack = 1'b0;
    for (int i = 0; i < 4; i++) cpu_write(32'h0000_0200 + 32'(i), 16'hA000 + 16'(i), 1'b1);
    cpu_write(32'h0000_0204, 16'hA004, 1'b0);
    @(negedge clk);
    chk("ovf_before", wbuf_overflow, 1'b0);
    cpu_nop();
    @(negedge clk);
    chk("ovf_set", wbuf_overflow, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("ovf_sticky", wbuf_overflow, 1'b1);
    end
    manual = 1'b0;
    lat_fixed = -1;
    drain("ovf_drain_timeout");
    chk("ovf_sticky_after_drain", wbuf_overflow, 1'b1);

    // Fifth write accepted when a pop happens on the same edge.
    do_reset();
    @(negedge clk);
    chk("ovf_cleared_by_reset", wbuf_overflow, 1'b0);
    manual = 1'b1;
    manual_ack = 1'b0;
    for (int i = 0; i < 4; i++) cpu_write(32'h0000_0300 + 32'(i), 16'hB000 + 16'(i), 1'b1);
    cpu_write(32'h0000_0304, 16'hB004, 1'b1);
    manual_ack = 1'b1;
    cpu_nop();
    manual_ack = 1'b0;
    @(negedge clk);
    chk("push_pop_no_ovf", wbuf_overflow, 1'b0);
    manual = 1'b0;
    drain("push_pop_drain_timeout");
    chk("push_pop_ovf_final", wbuf_overflow, 1'b0);

    // Reset in the middle of a CPU read aborts it without a ready pulse.
    do_reset();
    manual = 1'b1;
    manual_ack = 1'b0;
    @(posedge clk);
    #1;
    cpu_re = 1'b1;
    cpu_addr = 32'h0000_2000;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("midrst_req_seen", lat, 1);
    chk("midrst_is_read", {mem_we, mem_addr}, {1'b0, 32'h0000_2000});
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_re = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    manual_ack = 1'b1;
    @(negedge clk);
    chk("midrst_req_dropped", mem_req, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_ready", {cpu_ready, mem_req}, 2'b00);
    end
    @(posedge clk);
    #1;
    manual_ack = 1'b0;
    manual = 1'b0;
    lat_fixed = 0;
    cpu_read(32'h0000_2000, lat);
    chk("midrst_idle_latency", lat, 2);

    // Randomised traffic from both masters.
    do_reset();
    lat_fixed = -1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int op;
          op = int'($urandom_range(0, 2));
          if (op == 0 && exp_wr_q.size() < 4)
            cpu_write(32'h0000_0100 + 32'($urandom_range(0, 7)), 16'($urandom), 1'b1);
          else if (op == 1) cpu_read(32'h0000_0100 + 32'($urandom_range(0, 7)), lat);
          else cpu_nop();
        end
        cpu_nop();
      end
      begin
        for (int i = 0; i < 20; i++) begin
          aux_xact(1'($urandom_range(0, 1)), {AuxPage, 8'h00} + 32'($urandom_range(0, 7)),
                   16'($urandom));
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
      end
    join
    drain("random_drain_timeout");
    chk("random_no_overflow", wbuf_overflow, 1'b0);
    chk("left_writes", exp_wr_q.size(), 0);
    chk("left_reads", exp_rd_q.size(), 0);
    chk("left_aux", exp_aux_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
